// File: rtl/ram_8x8_pkg.sv
// Shared sizing constants and helpers for the 8x8 register-file RAM.
package ram_8x8_pkg;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  localparam logic [WIDTH-1:0] RST_VAL = 8'h00;

  function automatic logic [DEPTH-1:0] onehot(
    input logic [ADDR_W-1:0] a
  );
    logic [DEPTH-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/ram_8x8_word.sv
// One WIDTH-bit storage word with synchronous reset and write enable.
module ram_8x8_word
  import ram_8x8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (we) begin
      r_q <= D;
    end
  end

  assign Q = r_q;
endmodule

// File: rtl/ram_8x8.sv
// Single-port 8x8 flop RAM with registered read data.
// Define RAM8X8_WRITE_THROUGH_EN to make Q follow D on write cycles.
module ram_8x8
  import ram_8x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we
);
  logic [DEPTH-1:0] w_wen;
  logic [WIDTH-1:0] w_mem [DEPTH];
  logic [WIDTH-1:0] w_rd;
  logic [WIDTH-1:0] r_q;

  assign w_wen = we ? onehot(addr) : '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    ram_8x8_word u_word (
      .clk (clk),
      .rst (rst),
      .we  (w_wen[i]),
      .D   (D),
      .Q   (w_mem[i])
    );
  end

  assign w_rd = w_mem[addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (!we) begin
      r_q <= w_rd;
`ifdef RAM8X8_WRITE_THROUGH_EN
    end else begin
      r_q <= D;
`endif
    end
  end

  assign Q = r_q;
endmodule

// File: tb/tb_ram_8x8.sv
// Directed plan plus random traffic checked against an array model.
module tb_ram_8x8;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] D;
  logic [7:0] Q;
  logic [2:0] addr;
  logic       we;

  logic [7:0] m_mem [8];
  logic [7:0] m_q;
  int         n_vec;
  int         n_err;

  ram_8x8 dut (
    .clk  (clk),
    .rst  (rst),
    .D    (D),
    .Q    (Q),
    .addr (addr),
    .we   (we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic w,
                      input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    rst  = r;
    we   = w;
    addr = a;
    D    = d;
    @(posedge clk);
    if (r) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_q = 8'h00;
    end else if (w) begin
      m_mem[a] = d;
`ifdef RAM8X8_WRITE_THROUGH_EN
      m_q = d;
`endif
    end else begin
      m_q = m_mem[a];
    end
    #1;
    chk(tag, Q, m_q);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_q = 8'h00;
    rst = 1'b1; we = 1'b0; addr = '0; D = '0;

    step("rst0", 1'b1, 1'b1, 3'd1, 8'h11);
    step("rst1", 1'b1, 1'b0, 3'd2, 8'h22);
    for (int i = 0; i < 8; i++) step("rd_rst", 1'b0, 1'b0, 3'(i), 8'h00);

    for (int i = 0; i < 8; i++) step("fill", 1'b0, 1'b1, 3'(i), 8'hFF);
    for (int i = 0; i < 8; i++) step("rd_ff", 1'b0, 1'b0, 3'(i), 8'h00);

    for (int i = 0; i < 8; i++)
      step("wr_pat", 1'b0, 1'b1, 3'(i), 8'((i << 4) | (i + 1)));
    for (int i = 7; i >= 0; i--) step("rd_pat", 1'b0, 1'b0, 3'(i), 8'h00);

    step("wr3", 1'b0, 1'b1, 3'd3, 8'hA5);
    step("wr4", 1'b0, 1'b1, 3'd4, 8'h5A);
    for (int i = 0; i < 8; i++) step("iso", 1'b0, 1'b0, 3'(i), 8'h00);

    step("rd2", 1'b0, 1'b0, 3'd2, 8'h00);
    chk("rd2_val", Q, 8'h23);
    step("wq2", 1'b0, 1'b1, 3'd2, 8'hC3);
    step("rd2b", 1'b0, 1'b0, 3'd2, 8'h00);
    chk("rd2b_val", Q, 8'hC3);

    step("rst_wr", 1'b1, 1'b1, 3'd5, 8'h99);
    for (int i = 0; i < 8; i++) step("rd_clr", 1'b0, 1'b0, 3'(i), 8'h00);

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 29) == 0), 1'($urandom),
           3'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++) step("rd_end", 1'b0, 1'b0, 3'(i), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
